// File: rtl/fft_bfly_pipe.sv
// Pipelined radix-2 DIF butterfly: sum = a+b exact, prod = (b-a)*W (or conj(W)) rounded half-up and saturated.
// Three register stages with a shared stall; a sticky ovf flag records any saturated product.
module fft_bfly_pipe #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 15,
    localparam int OW  = DW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inv,
    input  logic signed [DW-1:0] real_a,
    input  logic signed [DW-1:0] imag_a,
    input  logic signed [DW-1:0] real_b,
    input  logic signed [DW-1:0] imag_b,
    input  logic signed [CW-1:0] real_w,
    input  logic signed [CW-1:0] imag_w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] real_sum,
    output logic signed [OW-1:0] imag_sum,
    output logic signed [OW-1:0] real_prod,
    output logic signed [OW-1:0] imag_prod,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    localparam int PW = OW + CW;
    localparam int AW = OW + CW + 1;

    localparam logic signed [AW-1:0] RND_C   = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [OW-1:0]        OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]        OUT_MIN = {1'b1, {(OW-1){1'b0}}};

    // Returns {clamped, value}: add half an LSB, arithmetic shift, then clamp to OW bits.
    function automatic logic [OW:0] rnd_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] rnd_v;
        logic signed [AW-1:0] shf_v;
        rnd_v = acc + RND_C;
        shf_v = rnd_v >>> FRAC;
        if (shf_v > SAT_MAX) begin
            rnd_sat = {1'b1, OUT_MAX};
        end else if (shf_v < SAT_MIN) begin
            rnd_sat = {1'b1, OUT_MIN};
        end else begin
            rnd_sat = {1'b0, shf_v[OW-1:0]};
        end
    endfunction

    logic                 en_s;
    logic                 v1_r, v2_r, v3_r;
    logic                 inv1_r, inv2_r;
    logic signed [OW-1:0] sum_re1_r, sum_im1_r, x_re1_r, x_im1_r;
    logic signed [CW-1:0] w_re1_r, w_im1_r;
    logic signed [OW-1:0] sum_re2_r, sum_im2_r;
    logic signed [PW-1:0] p_rr2_r, p_ii2_r, p_ri2_r, p_ir2_r;
    logic signed [AW-1:0] acc_re_s, acc_im_s;
    logic [OW:0]          res_re_s, res_im_s;
    logic                 clamp_s;

    // Stall only when the output register is full and not being drained.
    assign en_s      = out_ready | ~v3_r;
    assign in_ready  = en_s;
    assign out_valid = v3_r;

    // Combine the four partial products for the selected direction, then round and saturate.
    always_comb begin
        acc_re_s = '0;
        acc_im_s = '0;
        if (inv2_r) begin
            acc_re_s = AW'(p_rr2_r) + AW'(p_ii2_r);
            acc_im_s = AW'(p_ir2_r) - AW'(p_ri2_r);
        end else begin
            acc_re_s = AW'(p_rr2_r) - AW'(p_ii2_r);
            acc_im_s = AW'(p_ri2_r) + AW'(p_ir2_r);
        end
        res_re_s = rnd_sat(acc_re_s);
        res_im_s = rnd_sat(acc_im_s);
        clamp_s  = res_re_s[OW] | res_im_s[OW];
    end

    // Three-stage pipeline with common enable, plus the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            v3_r      <= 1'b0;
            inv1_r    <= 1'b0;
            inv2_r    <= 1'b0;
            sum_re1_r <= '0;
            sum_im1_r <= '0;
            x_re1_r   <= '0;
            x_im1_r   <= '0;
            w_re1_r   <= '0;
            w_im1_r   <= '0;
            sum_re2_r <= '0;
            sum_im2_r <= '0;
            p_rr2_r   <= '0;
            p_ii2_r   <= '0;
            p_ri2_r   <= '0;
            p_ir2_r   <= '0;
            real_sum  <= '0;
            imag_sum  <= '0;
            real_prod <= '0;
            imag_prod <= '0;
            ovf       <= 1'b0;
        end else begin
            if (en_s) begin
                v1_r      <= in_valid;
                inv1_r    <= inv;
                sum_re1_r <= OW'(real_b) + OW'(real_a);
                sum_im1_r <= OW'(imag_b) + OW'(imag_a);
                x_re1_r   <= OW'(real_b) - OW'(real_a);
                x_im1_r   <= OW'(imag_b) - OW'(imag_a);
                w_re1_r   <= real_w;
                w_im1_r   <= imag_w;

                v2_r      <= v1_r;
                inv2_r    <= inv1_r;
                sum_re2_r <= sum_re1_r;
                sum_im2_r <= sum_im1_r;
                p_rr2_r   <= PW'(x_re1_r) * PW'(w_re1_r);
                p_ii2_r   <= PW'(x_im1_r) * PW'(w_im1_r);
                p_ri2_r   <= PW'(x_re1_r) * PW'(w_im1_r);
                p_ir2_r   <= PW'(x_im1_r) * PW'(w_re1_r);

                v3_r      <= v2_r;
                real_sum  <= sum_re2_r;
                imag_sum  <= sum_im2_r;
                real_prod <= res_re_s[OW-1:0];
                imag_prod <= res_im_s[OW-1:0];
            end else begin
                v1_r <= v1_r;
            end
            // A clamped sample entering the output register beats a simultaneous clear.
            if (en_s && v2_r && clamp_s) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end else begin
                ovf <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed bench for fft_bfly_pipe: inputs driven and outputs sampled on the falling edge.
module tb_fft_bfly_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, inv;
    logic signed [15:0] real_a, imag_a, real_b, imag_b, real_w, imag_w;
    logic               out_valid, out_ready;
    logic signed [16:0] real_sum, imag_sum, real_prod, imag_prod;
    logic               ovf, clr_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fft_bfly_pipe #(.DW(16), .CW(16), .FRAC(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
        .real_a(real_a), .imag_a(imag_a), .real_b(real_b), .imag_b(imag_b),
        .real_w(real_w), .imag_w(imag_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .real_sum(real_sum), .imag_sum(imag_sum),
        .real_prod(real_prod), .imag_prod(imag_prod),
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    task automatic set_in(input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi, input logic iv);
        real_a = 16'(ar); imag_a = 16'(ai);
        real_b = 16'(br); imag_b = 16'(bi);
        real_w = 16'(wr); imag_w = 16'(wi);
        inv    = iv;
    endtask

    // Present one sample for one cycle (out_ready=1 so it is always accepted).
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input logic iv);
        set_in(ar, ai, br, bi, wr, wi, iv);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({real_sum, imag_sum, real_prod, imag_prod} !== 68'd0) begin
            n_err++; $display("FAIL reset_data: got %0d %0d %0d %0d want all 0", real_sum, imag_sum, real_prod, imag_prod);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        send(0, 0, 1000, -2000, 16'h4000, 0, 1'b0);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %b want 1", out_valid); end
        n_cmp++; if (real_sum !== 17'sd1000) begin n_err++; $display("FAIL basic_real_sum: got %0d want 1000", real_sum); end
        n_cmp++; if (imag_sum !== -17'sd2000) begin n_err++; $display("FAIL basic_imag_sum: got %0d want -2000", imag_sum); end
        n_cmp++; if (real_prod !== 17'sd500) begin n_err++; $display("FAIL basic_real_prod: got %0d want 500", real_prod); end
        n_cmp++; if (imag_prod !== -17'sd1000) begin n_err++; $display("FAIL basic_imag_prod: got %0d want -1000", imag_prod); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_single_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_rounding;
        send(0, 0, 3, 0, 16'h4000, 0, 1'b0);
        send(0, 0, -3, 0, 16'h4000, 0, 1'b0);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || real_prod !== 17'sd2) begin
            n_err++; $display("FAIL round_pos: got v=%b %0d want v=1 2", out_valid, real_prod);
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || real_prod !== -17'sd1) begin
            n_err++; $display("FAIL round_neg: got v=%b %0d want v=1 -1", out_valid, real_prod);
        end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL round_ovf: got %b want 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        send(-32768, -32768, 32767, 32767, 16'h7FFF, 16'h8000, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", out_valid); end
        n_cmp++; if (real_prod !== 17'sd65535) begin n_err++; $display("FAIL sat_real_prod: got %0d want 65535", real_prod); end
        n_cmp++; if (imag_prod !== -17'sd2) begin n_err++; $display("FAIL sat_imag_prod: got %0d want -2", imag_prod); end
        n_cmp++; if (real_sum !== -17'sd1 || imag_sum !== -17'sd1) begin
            n_err++; $display("FAIL sat_sum: got %0d %0d want -1 -1", real_sum, imag_sum);
        end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf_set: got %b want 1", ovf); end
        repeat (3) @(negedge clk);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf_sticky: got %b want 1", ovf); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL sat_ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_inv;
        logic iv_seq [6];
        iv_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 1000, 0, 16'h4000, iv_seq[i]);
            in_valid = 1'b1;
            @(negedge clk);
            if (i >= 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || real_prod !== (iv_seq[i-2] ? 17'sd500 : -17'sd500) || imag_prod !== 17'sd0) begin
                    n_err++; $display("FAIL inv_%0d: got v=%b (%0d,%0d) inv=%b", i - 2, out_valid, real_prod, imag_prod, iv_seq[i-2]);
                end
            end
        end
        in_valid = 1'b0;
        for (int i = 4; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || real_prod !== (iv_seq[i] ? 17'sd500 : -17'sd500) || imag_prod !== 17'sd0) begin
                n_err++; $display("FAIL inv_%0d: got v=%b (%0d,%0d) inv=%b", i, out_valid, real_prod, imag_prod, iv_seq[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int idx_in, idx_out, cyc;
        logic acc_in, acc_out, held;
        logic signed [16:0] h_rs, h_is, h_rp, h_ip;
        idx_in = 0; idx_out = 0; cyc = 0; held = 1'b0;
        h_rs = '0; h_is = '0; h_rp = '0; h_ip = '0;
        while (idx_out < 8 && cyc < 60) begin
            out_ready = !(cyc >= 2 && cyc <= 6);
            in_valid  = (idx_in < 8);
            set_in(0, 0, 100 * (idx_in + 1), -50 * (idx_in + 1), 16'h4000, 0, 1'b0);
            #1;
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || real_sum !== h_rs || imag_sum !== h_is || real_prod !== h_rp || imag_prod !== h_ip) begin
                    n_err++; $display("FAIL bp_stable cyc%0d: got v=%b %0d %0d %0d %0d want %0d %0d %0d %0d",
                                      cyc, out_valid, real_sum, imag_sum, real_prod, imag_prod, h_rs, h_is, h_rp, h_ip);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
            end
            acc_in  = in_valid & in_ready;
            acc_out = out_valid & out_ready;
            held    = out_valid & ~out_ready;
            h_rs = real_sum; h_is = imag_sum; h_rp = real_prod; h_ip = imag_prod;
            if (acc_out) begin
                n_cmp++;
                if (real_sum !== 17'(100 * (idx_out + 1)) || imag_sum !== 17'(-50 * (idx_out + 1)) ||
                    real_prod !== 17'(50 * (idx_out + 1)) || imag_prod !== 17'(-25 * (idx_out + 1))) begin
                    n_err++; $display("FAIL bp_data_%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", idx_out,
                                      real_sum, imag_sum, real_prod, imag_prod,
                                      100 * (idx_out + 1), -50 * (idx_out + 1), 50 * (idx_out + 1), -25 * (idx_out + 1));
                end
                idx_out++;
            end
            if (acc_in) idx_in++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (idx_out != 8) begin n_err++; $display("FAIL bp_count: got %0d outputs want 8", idx_out); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_duplicate cyc%0d: got out_valid=%b want 0", i, out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream;
        for (int i = 0; i < 3; i++) begin
            set_in(-32768, -32768, 32767, 32767, 16'h7FFF, 16'h8000, 1'b0);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || ovf !== 1'b1) begin
            n_err++; $display("FAIL mid_prefill: got v=%b ovf=%b want 1 1", out_valid, ovf);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL mid_ovf: got %b want 0", ovf); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({real_sum, imag_sum, real_prod, imag_prod} !== 68'd0) begin
            n_err++; $display("FAIL mid_data: got %0d %0d %0d %0d want all 0", real_sum, imag_sum, real_prod, imag_prod);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale cyc%0d: got out_valid=%b want 0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_inv();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
